// File: rtl/soc_rst_seq.sv
// SoC reset sequencer: qualifies lock/aux/software reset sources, holds all domains
// in reset for a minimum time, then releases them in order from channel 0 up.
module soc_rst_seq #(
   parameter int NUM_CH      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_DLY   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              locked,
   input  logic              aux_rst_n,
   input  logic              sw_rst_req,
   input  logic              cause_clr,
   output logic [NUM_CH-1:0] rst_n_out,
   output logic              rst_active,
   output logic [3:0]        rst_cause
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int SW = $clog2(STAGE_DLY + 1);
   localparam int CW = $clog2(NUM_CH + 1);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_DLY - 1);
   localparam logic [CW-1:0] CH_LAST    = CW'(NUM_CH - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] lock_sync_q, aux_sync_q;
   logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
   logic                   aux_act_q, aux_act_d;
   logic                   lock_seen_q;
   logic [HW-1:0]          hold_q, hold_d;
   logic [SW-1:0]          stage_q, stage_d;
   logic [CW-1:0]          ch_q, ch_d;
   logic [NUM_CH-1:0]      rst_n_out_q, rst_n_out_d;
   logic                   rst_active_q, rst_active_d;
   logic [3:0]             rst_cause_q, rst_cause_d;

   logic       locked_s, aux_s, trig;
   logic [3:0] cause_set;

   assign locked_s  = lock_sync_q[SYNC_STAGES-1];
   assign aux_s     = aux_sync_q[SYNC_STAGES-1];
   assign trig      = !locked_s | aux_act_q | sw_rst_req;
   // Lock loss is only a cause once lock has been seen; the power-on unlocked phase is POR.
   assign cause_set = {sw_rst_req, aux_act_q, !locked_s & lock_seen_q, 1'b0};

   always_comb begin
      deb_cnt_d = deb_cnt_q;
      aux_act_d = aux_act_q;
      if (aux_s) begin
         deb_cnt_d = '0;
         aux_act_d = 1'b0;
      end else if (!aux_act_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            aux_act_d = 1'b1;
            deb_cnt_d = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      rst_cause_d = (cause_clr ? 4'b0000 : rst_cause_q) | (trig ? cause_set : 4'b0000);
   end

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      stage_d      = stage_q;
      ch_d         = ch_q;
      rst_n_out_d  = rst_n_out_q;
      rst_active_d = rst_active_q;
      unique case (state_q)
         ST_ASSERT: begin
            rst_n_out_d  = '0;
            rst_active_d = 1'b1;
            if (trig) begin
               hold_d = '0;
            end else if (hold_q == HOLD_LAST) begin
               hold_d  = '0;
               stage_d = '0;
               if (NUM_CH == 1) begin
                  state_d      = ST_RUN;
                  rst_n_out_d  = '1;
                  rst_active_d = 1'b0;
               end else begin
                  state_d     = ST_RELEASE;
                  rst_n_out_d = NUM_CH'(1);
                  ch_d        = CW'(1);
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (stage_q == STAGE_LAST) begin
               stage_d     = '0;
               rst_n_out_d = rst_n_out_q | (NUM_CH'(1) << ch_q);
               ch_d        = ch_q + 1'b1;
               if (ch_q == CH_LAST) begin
                  state_d      = ST_RUN;
                  rst_active_d = 1'b0;
               end
            end else begin
               stage_d = stage_q + 1'b1;
            end
         end
         default: ;
      endcase
      // Any trigger outside ASSERT aborts the sequence and pulls every domain back into reset.
      if (trig && state_q != ST_ASSERT) begin
         state_d      = ST_ASSERT;
         hold_d       = '0;
         stage_d      = '0;
         ch_d         = '0;
         rst_n_out_d  = '0;
         rst_active_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ASSERT;
         lock_sync_q  <= '0;
         aux_sync_q   <= '0;
         deb_cnt_q    <= '0;
         aux_act_q    <= 1'b0;
         lock_seen_q  <= 1'b0;
         hold_q       <= '0;
         stage_q      <= '0;
         ch_q         <= '0;
         rst_n_out_q  <= '0;
         rst_active_q <= 1'b1;
         rst_cause_q  <= 4'b0001;
      end else begin
         state_q      <= state_d;
         lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], locked};
         aux_sync_q   <= {aux_sync_q[SYNC_STAGES-2:0], aux_rst_n};
         deb_cnt_q    <= deb_cnt_d;
         aux_act_q    <= aux_act_d;
         lock_seen_q  <= lock_seen_q | locked_s;
         hold_q       <= hold_d;
         stage_q      <= stage_d;
         ch_q         <= ch_d;
         rst_n_out_q  <= rst_n_out_d;
         rst_active_q <= rst_active_d;
         rst_cause_q  <= rst_cause_d;
      end
   end

   assign rst_n_out  = rst_n_out_q;
   assign rst_active = rst_active_q;
   assign rst_cause  = rst_cause_q;

endmodule
